// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier for MULT/MULTU.
// Retires one multiplier bit per clock. A start/busy/done handshake
// frames each operation. Signed operands are reduced to magnitudes and
// the sign is applied to the 2*WIDTH-bit result in the final cycle.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mplier_shift;
    logic [WIDTH-1:0]     mcand;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_in;

    // Operand magnitudes and the result sign, taken from the live inputs at accept time.
    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    always_comb begin
        mag_a  = (sign_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b  = (sign_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_in = sign_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // Control FSM plus datapath: accept, WIDTH shift-add iterations, sign fix-up.
    // NOTE: every register in this block, datapath included, is cleared by the
    // synchronous reset so an aborted operation leaves no stale state behind, and
    // all of them use non-blocking assignments so each edge sees the previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            z            <= '0;
            cnt          <= '0;
            acc          <= '0;
            mplier_shift <= '0;
            mcand        <= '0;
            neg          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand        <= mag_a;
                        mplier_shift <= {{WIDTH{1'b0}}, mag_b};
                        neg          <= neg_in;
                        acc          <= '0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    if (mcand[0]) begin
                        acc <= acc + mplier_shift;
                    end
                    mplier_shift <= mplier_shift << 1;
                    mcand        <= mcand >> 1;
                    cnt          <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    z     <= neg ? (~acc + 1'b1) : acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
